// File: rtl/ram_tester.sv
// Built-in self test for a 4x4 synchronous-read RAM: write (seed+a) patterns, read back and compare.
// Optional inverted second pass enabled by defining RAM_TESTER_INV_PASS_EN.
module ram_tester (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [3:0] seed,
  output logic       rw,
  output logic [1:0] addr,
  output logic [3:0] wdata,
  input  logic [3:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_cnt,
  output logic [1:0] err_addr
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t     state, state_nxt;
  logic       rw_nxt;
  logic [1:0] addr_nxt;
  logic [3:0] wdata_nxt;
  logic [3:0] seed_q;
  logic       inv;
  logic       cmp_vld;
  logic [1:0] cmp_addr;
  logic [3:0] cmp_exp;
  logic       mism;
  logic [3:0] fail_nxt;

  function automatic logic [3:0] pat(input logic [3:0] base, input logic [1:0] a,
                                     input logic inv_f);
    logic [3:0] p;
    p = base + {2'b00, a};
    return inv_f ? ~p : p;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rw_nxt    = 1'b0;
    addr_nxt  = '0;
    wdata_nxt = '0;
    case (state)
      IDLE: if (start) begin
        state_nxt = WRITE;
        rw_nxt    = 1'b1;
        wdata_nxt = pat(seed, 2'd0, 1'b0);
      end
      WRITE: if (addr == 2'd3) begin
        state_nxt = READ;
      end else begin
        rw_nxt    = 1'b1;
        addr_nxt  = addr + 2'd1;
        wdata_nxt = pat(seed_q, addr + 2'd1, inv);
      end
      READ: if (addr == 2'd3) state_nxt = DRAIN;
            else              addr_nxt  = addr + 2'd1;
      DRAIN: begin
`ifdef RAM_TESTER_INV_PASS_EN
        if (!inv) begin
          state_nxt = WRITE;
          rw_nxt    = 1'b1;
          wdata_nxt = pat(seed_q, 2'd0, 1'b1);
        end else begin
          state_nxt = DONE;
        end
`else
        state_nxt = DONE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data arrives one cycle after its address, so expected values ride a one-stage pipe.
  assign mism = cmp_vld && (rdata != cmp_exp);

  always_comb begin
    fail_nxt = fail_cnt;
    if (mism && fail_cnt != 4'hF) fail_nxt = fail_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rw       <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_cnt <= '0;
      err_addr <= '0;
      seed_q   <= '0;
      inv      <= 1'b0;
      cmp_vld  <= 1'b0;
      cmp_addr <= '0;
      cmp_exp  <= '0;
    end else begin
      rw       <= rw_nxt;
      addr     <= addr_nxt;
      wdata    <= wdata_nxt;
      busy     <= (state_nxt == WRITE) || (state_nxt == READ) || (state_nxt == DRAIN);
      done     <= (state_nxt == DONE);
      cmp_vld  <= (state == READ);
      cmp_addr <= addr;
      cmp_exp  <= pat(seed_q, addr, inv);
      if (state == IDLE && start) begin
        seed_q   <= seed;
        inv      <= 1'b0;
        pass     <= 1'b0;
        fail_cnt <= '0;
        err_addr <= '0;
      end else begin
        fail_cnt <= fail_nxt;
        if (mism && fail_cnt == 4'd0) err_addr <= cmp_addr;
        // Includes the final DRAIN compare so pass is valid alongside done.
        if (state_nxt == DONE) pass <= (fail_nxt == 4'd0);
        if (state == DRAIN && state_nxt == WRITE) inv <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_tester.sv
// Scoreboard bench for ram_tester with a behavioural 4x4 RAM offering ideal, stuck-bit and all-zero faults.
module tb_ram_tester;

`ifdef RAM_TESTER_INV_PASS_EN
  localparam int NPASS    = 2;
  localparam int DONE_CYC = 19;
`else
  localparam int NPASS    = 1;
  localparam int DONE_CYC = 10;
`endif

  logic       clk = 1'b0;
  logic       clr, start;
  logic [3:0] seed;
  logic       rw;
  logic [1:0] addr;
  logic [3:0] wdata;
  logic [3:0] rdata;
  logic       busy, done, pass;
  logic [3:0] fail_cnt;
  logic [1:0] err_addr;

  int checks = 0;
  int errors = 0;
  int mode   = 0;

  typedef struct { int cyc; int a; int d; } wr_t;
  typedef struct { int fc; int ea; int ps; } res_t;
  wr_t  wq[$];
  res_t rq[$];

  logic [3:0] mem [4];

  ram_tester dut (
    .clk(clk), .clr(clr), .start(start), .seed(seed), .rw(rw), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .pass(pass),
    .fail_cnt(fail_cnt), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM; mode 1: addr 1 bit 2 stuck at 1, mode 2: reads return 0.
  always @(posedge clk) begin
    if (rw) mem[addr] <= wdata;
    if (mode == 2)                    rdata <= 4'h0;
    else if (mode == 1 && addr == 2'd1) rdata <= mem[addr] | 4'h4;
    else                              rdata <= mem[addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_expect(input logic [3:0] s, input int m);
    res_t r;
    logic [3:0] d, rd;
    r.fc = 0; r.ea = 0;
    for (int p = 0; p < NPASS; p++) begin
      for (int a = 0; a < 4; a++) begin
        d = s + 4'(a);
        if (p == 1) d = ~d;
        wq.push_back('{cyc: 1 + 9 * p + a, a: a, d: int'(d)});
        if (m == 2)                rd = 4'h0;
        else if (m == 1 && a == 1) rd = d | 4'h4;
        else                       rd = d;
        if (rd != d) begin
          if (r.fc == 0) r.ea = a;
          if (r.fc < 15) r.fc++;
        end
      end
    end
    r.ps = (r.fc == 0) ? 1 : 0;
    rq.push_back(r);
  endtask

  task automatic run_test(input logic [3:0] s, input int m);
    res_t r;
    wr_t  w;
    bit   got_done;
    push_expect(s, m);
    r = '{fc: 0, ea: 0, ps: 0};
    mode  = m;
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("pass_cleared", pass, 0);
    check("fail_cleared", fail_cnt, 0);
    got_done = 0;
    for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (rw) begin
        if (wq.size() == 0) check("wr_extra", 1, 0);
        else begin
          w = wq.pop_front();
          check("wr_cycle", cyc, w.cyc);
          check("wr_addr", addr, w.a);
          check("wr_data", wdata, w.d);
        end
      end
      check("busy", busy, (cyc < DONE_CYC) ? 1 : 0);
      if (done) begin
        got_done = 1;
        check("done_cycle", cyc, DONE_CYC);
        if (rq.size() == 0) check("res_missing", 1, 0);
        else begin
          r = rq.pop_front();
          check("fail_cnt", fail_cnt, r.fc);
          check("err_addr", err_addr, r.ea);
        end
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("pass", pass, r.ps);
    check("fail_hold", fail_cnt, r.fc);
    check("wr_missing", wq.size(), 0);
  endtask

  initial begin
    int   ndone, last;
    bit   saw_done, saw_rw;
    clr = 1'b1; start = 1'b0; seed = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rw", rw, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_err", err_addr, 0);
    clr = 1'b0;
    @(negedge clk);

    run_test(4'hE, 0);
    run_test(4'h0, 1);
    run_test(4'h1, 2);
    run_test(4'hF, 0);

    // Abort mid-run with clr during cycle 6.
    mode = 0; seed = 4'h5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_rw", rw, 0);
    check("abort_done", done, 0);
    clr = 1'b0;
    saw_done = 0; saw_rw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (rw)   saw_rw = 1;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_no_rw", saw_rw, 0);
    run_test(4'h5, 0);

    // start and clr on the same edge.
    start = 1'b1; clr = 1'b1;
    @(negedge clk);
    check("sc_busy", busy, 0);
    check("sc_rw", rw, 0);
    start = 1'b0; clr = 1'b0;
    @(negedge clk);
    check("sc_idle", busy, 0);

    // start held for 25 edges: back-to-back runs, one done per run.
    mode = 0; seed = 4'h3; start = 1'b1;
    ndone = 0; last = -1;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (last < 0) check("b2b_first", c, DONE_CYC);
        else          check("b2b_period", c - last, DONE_CYC + 1);
        check("b2b_fail", fail_cnt, 0);
        last = c;
      end
      if (c == 24) start = 1'b0;
    end
    check("b2b_runs", ndone, 24 / (DONE_CYC + 1) + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
